mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
// Memory-mapped UART transmitter that answers the core's data-port bus (d_addr/dw_data/dw_size/d_data).
// Stores from the core push bytes into a FIFO, which serialises them 8N1, LSB first, on tx.
// Reads return a status word with the same 1-cycle registered latency as the RAM.
// Sits beside the RAM on the data port; the top level ORs d_data (0 when not addressed) with RAM data.
// PARAMETERS
// CLKS_PER_BIT  16       clk cycles per serial bit (>=2)
// FIFO_DEPTH    8        TX FIFO entries (power of 2, >=2)
// BASE_ADDR     14'h3FF0 8-byte-aligned base; +0 TXDATA, +4 STATUS
// PORTS
// clk      in   1   clock, all logic on posedge
// resetn   in   1   synchronous reset, active-high (despite name)
// d_addr   in   14  byte address from core
// dw_data  in   32  store data; byte always taken from [7:0]
// dw_size  in   2   00 none, 01 byte, 10 half, 11 word; any nonzero = write
// d_data   out  32  registered read data
// tx       out  1   serial line, idle high
// tx_busy  out  1   FSM not IDLE or FIFO not empty
// BEHAVIOUR
// - Reset (resetn=1 at edge): tx=1, d_data=0, FIFO flushed (ptrs/count 0), FSM IDLE, baud cnt 0, overflow=0.
//   Mid-frame reset truncates the frame; tx high from that edge on.
// - Hit: d_addr[13:3]==BASE_ADDR[13:3]; d_addr[2] selects reg; d_addr[1:0] ignored.
// - TXDATA write (hit, d_addr[2]=0, dw_size!=0): push dw_data[7:0]. Accepted if count<FIFO_DEPTH
//   or a pop occurs the same edge; else dropped and overflow<=1 (sticky).
// - STATUS write (hit, d_addr[2]=1, dw_size!=0): dw_data[8]=1 clears overflow; nothing else.
// - Read: every edge d_data <= STATUS if hit && d_addr[2]=1, else 0 (TXDATA reads 0, misses 0).
// - STATUS = {20'b0, overflow[11], tx_busy[10], full[9], empty[8], count[7:0] zero-extended}.
// - Count width $clog2(FIFO_DEPTH)+1; pointers wrap mod FIFO_DEPTH; no write bypass.
// - FSM IDLE/START/DATA/STOP; each bit held exactly CLKS_PER_BIT cycles.
//   IDLE & !empty: pop, load shifter, tx<=0, ->START. Push at edge N => tx low from edge N+1.
//   START -> DATA: 8 bits, shifter[0] first, shift right per bit.
//   DATA after bit 7 -> STOP: tx=1.
//   STOP end: !empty => pop, ->START same edge (no idle gap); else ->IDLE.
// - Frame = 10*CLKS_PER_BIT cycles; tx_busy combinational from state/empty.
// TESTING
// 1 Reset, LW STATUS -> d_data=0x00000100 one edge after address; tx=1, tx_busy=0.
// 2 SB 0x55 to 0x3FF0 (CLKS_PER_BIT=16) -> tx low 16 cyc, then 1,0,1,0,1,0,1,0, stop 1; busy low after 160 cyc.
// 3 Two SBs 0x41,0x42 back-to-back -> second start bit immediately after first stop; 320 cyc total.
// 4 Ten consecutive SW from idle (depth 8) -> 10th dropped, STATUS=0xE08; 9 bytes sent in order.
//   Then SW 0x100 to 0x3FF4 -> overflow bit clears.
// 5 SH 0x1234 to 0x3FF2 -> frame carries 0x34; LW 0x1000 (miss) -> d_data=0; LW 0x3FF0 -> 0.
// 6 resetn pulsed mid DATA bit 3 with 3 bytes queued -> tx=1 next edge, STATUS=0x100, no frames after.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core data port.
// TXDATA stores queue bytes in a FIFO; STATUS reads report FIFO and line state.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [13:0] BASE_ADDR    = 14'h3FF0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] d_addr,
    input  logic [31:0] dw_data,
    input  logic [1:0]  dw_size,
    output logic [31:0] d_data,
    output logic        tx,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // bus decode
    logic hit;
    logic wr;
    logic push_req;
    logic st_wr;

    assign hit      = (d_addr[13:3] == BASE_ADDR[13:3]);
    assign wr       = |dw_size;
    assign push_req = hit && !d_addr[2] && wr;
    assign st_wr    = hit && d_addr[2] && wr;

    logic unused_ok;
    assign unused_ok = ^{dw_data[31:9], d_addr[1:0]};

    // fifo state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          pop;
    logic [7:0]    fifo_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH);
    assign fifo_rd = mem_q[rd_ptr_q];

    // a pop on the same edge frees the slot a push into a full fifo needs
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dw_data[7:0];
        end
    end

    // overflow flag
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end else if (st_wr && dw_data[8]) begin
            overflow_d = 1'b0;
        end
    end

    // serialiser
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // chain straight into the next start bit
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    // status and read port
    logic [31:0] status;
    logic [31:0] d_data_q, d_data_d;

    assign tx_busy = (state_q != IDLE) || !empty;

    assign status = {20'b0, overflow_q, tx_busy, full, empty,
                     8'(count_q)};

    always_comb begin
        d_data_d = '0;
        if (hit && d_addr[2]) begin
            d_data_d = status;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            d_data_q   <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            d_data_q   <= d_data_d;
        end
    end

    assign tx     = tx_q;
    assign d_data = d_data_q;

endmodule
